// File: rtl/tx_pll_rst_seq_if.sv
// ============================================================================
// Module : tx_pll_rst_seq_if
// Brief  : Control/status bundle between the TX PLL reset sequencer and its
//          surroundings. relock_cnt exists only with TX_PLL_RELOCK_CNT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface tx_pll_rst_seq_if;
  logic       soft_reset;
  logic       pll_locked;
  logic       pll_rst;
  logic       tx_rst;
  logic       clk_ok;
  logic       fault;
  logic [2:0] state;
  logic [2:0] retry_cnt;
`ifdef TX_PLL_RELOCK_CNT_EN
  logic [7:0] relock_cnt;
`endif

  modport master (
    input  soft_reset,
    input  pll_locked,
    output pll_rst,
    output tx_rst,
    output clk_ok,
    output fault,
    output state,
`ifdef TX_PLL_RELOCK_CNT_EN
    output relock_cnt,
`endif
    output retry_cnt
  );

  modport slave (
    output soft_reset,
    output pll_locked,
    input  pll_rst,
    input  tx_rst,
    input  clk_ok,
    input  fault,
    input  state,
`ifdef TX_PLL_RELOCK_CNT_EN
    input  relock_cnt,
`endif
    input  retry_cnt
  );
endinterface

`default_nettype wire

// File: rtl/tx_pll_rst_seq.sv
// ============================================================================
// Module : tx_pll_rst_seq
// Brief  : Reset/lock sequencer for the 50->146 MHz TX PLL on refclk; retries
//          on lock timeout, faults when retries run out.
//          Optional relock counter: define TX_PLL_RELOCK_CNT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tx_pll_rst_seq #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned MAX_RETRY    = 7
) (
  input  wire logic        refclk,
  input  wire logic        rst,
  tx_pll_rst_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  localparam logic [15:0] C_RST_LAST     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] C_STABLE_LAST  = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] C_TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [2:0]  C_MAX_RETRY    = 3'(MAX_RETRY);

  logic        sync1_q;
  logic        locked_s_q;
  state_e      state_q,  state_d;
  logic [15:0] cnt_q,    cnt_d;
  logic [2:0]  retry_q,  retry_d;
  logic [2:0]  retry_inc;
  logic        pll_rst_q;
  logic        tx_rst_q;
  logic        clk_ok_q;
  logic        fault_q;
`ifdef TX_PLL_RELOCK_CNT_EN
  logic [7:0]  relock_q;
`endif

  assign retry_inc = retry_q + 3'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (bus.soft_reset) begin
      state_d = S_PLL_RST;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_PLL_RST: begin
          if (cnt_q == C_RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_WAIT_LOCK: begin
          // A lock seen on the timeout cycle still wins over the retry.
          if (locked_s_q) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == C_TIMEOUT_LAST) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc == C_MAX_RETRY) ? S_FAULT : S_PLL_RST;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_STABLE: begin
          if (!locked_s_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == C_STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_RUN: begin
          if (!locked_s_q) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
      state_q    <= S_PLL_RST;
      cnt_q      <= '0;
      retry_q    <= '0;
      pll_rst_q  <= 1'b1;
      tx_rst_q   <= 1'b1;
      clk_ok_q   <= 1'b0;
      fault_q    <= 1'b0;
`ifdef TX_PLL_RELOCK_CNT_EN
      relock_q   <= '0;
`endif
    end else begin
      sync1_q    <= bus.pll_locked;
      locked_s_q <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      pll_rst_q  <= (state_d == S_PLL_RST) || (state_d == S_FAULT);
      tx_rst_q   <= (state_d != S_RUN);
      clk_ok_q   <= (state_d == S_RUN);
      fault_q    <= (state_d == S_FAULT);
`ifdef TX_PLL_RELOCK_CNT_EN
      if ((state_q == S_RUN) && (state_d == S_PLL_RST) && (relock_q != 8'hFF))
        relock_q <= relock_q + 8'd1;
`endif
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.tx_rst    = tx_rst_q;
  assign bus.clk_ok    = clk_ok_q;
  assign bus.fault     = fault_q;
  assign bus.state     = state_q;
  assign bus.retry_cnt = retry_q;
`ifdef TX_PLL_RELOCK_CNT_EN
  assign bus.relock_cnt = relock_q;
`endif

endmodule

`default_nettype wire
